// File: rtl/usb_stream_arb_if.sv
// Stream-side and FT245-side signals of the USB stream arbiter.
// slave is the arbiter's view, master is the view of whatever drives it.
interface usb_stream_arb_if #(
    parameter int CHANNELS = 4
);
    logic [8*CHANNELS-1:0] in_data;
    logic [CHANNELS-1:0]   in_valid;
    logic [CHANNELS-1:0]   in_ready;
    logic [CHANNELS-1:0]   ch_en;
    logic                  usb_txe_n;
    logic                  usb_wr_n;
    logic [7:0]            usb_d;
    logic                  busy;

    modport slave (
        input  in_data, in_valid, ch_en, usb_txe_n,
        output in_ready, usb_wr_n, usb_d, busy
    );

    modport master (
        output in_data, in_valid, ch_en, usb_txe_n,
        input  in_ready, usb_wr_n, usb_d, busy
    );
endinterface

// File: rtl/usb_stream_arb.sv
// Per-channel byte FIFOs feeding a round-robin packetiser onto an FT245 sync FIFO.
// Packet format on usb_d: header {4'hA, 0, channel}, length byte, then payload.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | no packet; pick next eligible channel, latch length
// HDR    | header byte on usb_d, waiting for the FT245 to take it
// LEN    | length byte on usb_d
// DATA   | payload bytes from the granted FIFO, rem_q counts down
module usb_stream_arb #(
    parameter int CHANNELS   = 4,
    parameter int FIFO_DEPTH = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic            clk,
    input  logic            rst,
    usb_stream_arb_if.slave bus
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_LEN, S_DATA} state_t;

    logic [7:0]    mem_q    [CHANNELS][FIFO_DEPTH];
    logic [7:0]    mem_d    [CHANNELS][FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q [CHANNELS];
    logic [AW-1:0] wr_ptr_d [CHANNELS];
    logic [AW-1:0] rd_ptr_q [CHANNELS];
    logic [AW-1:0] rd_ptr_d [CHANNELS];
    logic [OW-1:0] occ_q    [CHANNELS];
    logic [OW-1:0] occ_d    [CHANNELS];

    state_t        state_q;
    logic [CW-1:0] grant_q;
    logic [CW-1:0] last_grant_q;
    logic [7:0]    len_q;
    logic [7:0]    rem_q;
    logic [7:0]    usb_d_q;
    logic          usb_wr_n_q;

    logic [CHANNELS-1:0] ready;
    logic [CHANNELS-1:0] push;
    logic [CHANNELS-1:0] pop;
    logic                accept;
    logic                found;
    logic [CW-1:0]       pick;
    logic [CW-1:0]       idx;
    logic [8:0]          pick_occ;
    logic [7:0]          pick_len;
    logic [AW-1:0]       rd_next;

    assign accept = !usb_wr_n_q && !bus.usb_txe_n;

    always_comb begin
        ready = '0;
        push  = '0;
        pop   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            ready[c] = (occ_q[c] != OW'(FIFO_DEPTH));
            push[c]  = bus.in_valid[c] && ready[c];
            pop[c]   = accept && (state_q == S_DATA) && (grant_q == CW'(c));
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        for (int c = 0; c < CHANNELS; c++) begin
            if (push[c]) begin
                mem_d[c][wr_ptr_q[c]] = bus.in_data[8*c +: 8];
                wr_ptr_d[c]           = wr_ptr_q[c] + 1'b1;
            end
            if (pop[c]) begin
                rd_ptr_d[c] = rd_ptr_q[c] + 1'b1;
            end
            // A push and a pop in the same cycle cancel out.
            case ({push[c], pop[c]})
                2'b10:   occ_d[c] = occ_q[c] + 1'b1;
                2'b01:   occ_d[c] = occ_q[c] - 1'b1;
                default: occ_d[c] = occ_q[c];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                occ_q[c]    <= '0;
            end
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Round-robin search starting one past the previous grant.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = CW'((int'(last_grant_q) + 1 + i) % CHANNELS);
            if (!found && bus.ch_en[idx] && (occ_q[idx] != '0)) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        pick_occ = 9'(occ_q[pick]);
        pick_len = (pick_occ > 9'(MAX_BURST)) ? 8'(MAX_BURST) : pick_occ[7:0];
        rd_next  = rd_ptr_q[grant_q] + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= CW'(CHANNELS - 1);
            len_q        <= '0;
            rem_q        <= '0;
            usb_d_q      <= '0;
            usb_wr_n_q   <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        state_q      <= S_HDR;
                        grant_q      <= pick;
                        last_grant_q <= pick;
                        len_q        <= pick_len;
                        rem_q        <= pick_len;
                        usb_d_q      <= {4'hA, 1'b0, 3'(pick)};
                        usb_wr_n_q   <= 1'b0;
                    end
                end
                S_HDR: begin
                    if (accept) begin
                        state_q <= S_LEN;
                        usb_d_q <= len_q;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        state_q <= S_DATA;
                        usb_d_q <= mem_q[grant_q][rd_ptr_q[grant_q]];
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        if (rem_q == 8'd1) begin
                            state_q    <= S_IDLE;
                            usb_d_q    <= '0;
                            usb_wr_n_q <= 1'b1;
                        end else begin
                            // len never exceeds occupancy, so the next slot is filled.
                            rem_q   <= rem_q - 8'd1;
                            usb_d_q <= mem_q[grant_q][rd_next];
                        end
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    usb_wr_n_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready = ready;
    assign bus.usb_wr_n = usb_wr_n_q;
    assign bus.usb_d    = usb_d_q;
    assign bus.busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_usb_stream_arb.sv
// Bench for usb_stream_arb: a queue-based packet model predicts every output
// each cycle; directed byte-stream scenarios are followed by random traffic.
module tb_usb_stream_arb;
    localparam int CH    = 4;
    localparam int DEPTH = 32;
    localparam int MB    = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    usb_stream_arb_if #(.CHANNELS(CH)) bus ();

    usb_stream_arb #(
        .CHANNELS  (CH),
        .FIFO_DEPTH(DEPTH),
        .MAX_BURST (MB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: channel queues, plus the packet in flight as bytes-left / length / channel.
    logic [7:0] mq [CH][$];
    int         m_left  = 0;
    int         m_len   = 0;
    int         m_g     = 0;
    int         m_last  = CH - 1;
    bit         m_valid = 1'b0;
    logic [7:0] cap [$];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic int m_exp_byte();
        if (m_left == m_len + 2) return 'hA0 | m_g;
        if (m_left == m_len + 1) return m_len;
        return int'(mq[m_g][0]);
    endfunction

    task automatic step(input logic r, input logic [CH-1:0] v, input logic [8*CH-1:0] d,
                        input logic [CH-1:0] en, input logic txe);
        logic [CH-1:0] rdy;
        bit            got_one;
        for (int c = 0; c < CH; c++) rdy[c] = (mq[c].size() < DEPTH);
        if (m_valid) begin
            check("wr_n", int'(bus.usb_wr_n), (m_left == 0) ? 1 : 0);
            check("busy", int'(bus.busy), (m_left != 0) ? 1 : 0);
            check("in_ready", int'(bus.in_ready), int'(rdy));
            if (m_left != 0) check("usb_d", int'(bus.usb_d), m_exp_byte());
        end
        rst           = r;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.ch_en     = en;
        bus.usb_txe_n = txe;
        if (!r && !bus.usb_wr_n && !txe) cap.push_back(bus.usb_d);
        @(posedge clk);
        if (r) begin
            for (int c = 0; c < CH; c++) mq[c].delete();
            m_left  = 0;
            m_len   = 0;
            m_g     = 0;
            m_last  = CH - 1;
            m_valid = 1'b1;
        end else begin
            if (m_left == 0) begin
                got_one = 1'b0;
                for (int i = 1; i <= CH; i++) begin
                    int ch;
                    ch = (m_last + i) % CH;
                    if (!got_one && en[ch] && mq[ch].size() > 0) begin
                        got_one = 1'b1;
                        m_g     = ch;
                        m_len   = (mq[ch].size() > MB) ? MB : mq[ch].size();
                        m_left  = m_len + 2;
                        m_last  = ch;
                    end
                end
            end else if (!txe) begin
                if (m_left <= m_len) void'(mq[m_g].pop_front());
                m_left--;
            end
            for (int c = 0; c < CH; c++)
                if (v[c] && rdy[c]) mq[c].push_back(d[8*c +: 8]);
        end
        @(negedge clk);
    endtask

    function automatic logic [8*CH-1:0] lane(input int c, input logic [7:0] b);
        logic [8*CH-1:0] r;
        r = '0;
        r[8*c +: 8] = b;
        return r;
    endfunction

    task automatic push1(input int c, input logic [7:0] b);
        step(1'b0, CH'(1) << c, lane(c, b), '0, 1'b0);
    endtask

    task automatic idle(input int n, input logic [CH-1:0] en, input logic txe);
        repeat (n) step(1'b0, '0, '0, en, txe);
    endtask

    task automatic do_reset();
        step(1'b1, '0, '0, '0, 1'b1);
        step(1'b1, '0, '0, '0, 1'b1);
        cap.delete();
    endtask

    task automatic check_cap(input string tag, input logic [7:0] exp[$], input bit exact);
        if (exact) check({tag, "_count"}, cap.size(), exp.size());
        else check({tag, "_enough"}, (cap.size() >= exp.size()) ? 1 : 0, 1);
        for (int i = 0; i < exp.size() && i < cap.size(); i++)
            check(tag, int'(cap[i]), int'(exp[i]));
        cap.delete();
    endtask

    initial begin
        logic [7:0]      e [$];
        logic [CH-1:0]   v;
        logic [CH-1:0]   en;
        logic [8*CH-1:0] d;
        int              nxt;
        bit              acc;

        rst           = 1'b1;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.ch_en     = '0;
        bus.usb_txe_n = 1'b1;
        @(negedge clk);
        do_reset();

        // Three bytes on channel 0 form one packet.
        push1(0, 8'h11); push1(0, 8'h22); push1(0, 8'h33);
        idle(8, 4'h1, 1'b0);
        e = {8'hA0, 8'h03, 8'h11, 8'h22, 8'h33};
        check_cap("basic", e, 1'b1);

        // Round robin ch1 then ch3, then wrap to ch0.
        do_reset();
        push1(1, 8'hB1); push1(1, 8'hB2); push1(3, 8'hD1); push1(3, 8'hD2);
        idle(12, 4'hF, 1'b0);
        e = {8'hA1, 8'h02, 8'hB1, 8'hB2, 8'hA3, 8'h02, 8'hD1, 8'hD2};
        check_cap("rr", e, 1'b1);
        push1(1, 8'hC1); push1(0, 8'hC0);
        idle(8, 4'hF, 1'b0);
        e = {8'hA0, 8'h01, 8'hC0, 8'hA1, 8'h01, 8'hC1};
        check_cap("rr_wrap", e, 1'b1);

        // 40 bytes through channel 2 split 16/16/8.
        do_reset();
        for (int i = 0; i < 32; i++) push1(2, 8'(i));
        nxt = 32;
        for (int k = 0; k < 60; k++) begin
            v   = (nxt < 40) ? 4'h4 : 4'h0;
            acc = (mq[2].size() < DEPTH);
            step(1'b0, v, lane(2, 8'(nxt)), 4'hF, 1'b0);
            if (v != 0 && acc) nxt++;
        end
        e.delete();
        for (int p = 0; p < 3; p++) begin
            e.push_back(8'hA2);
            e.push_back((p < 2) ? 8'd16 : 8'd8);
            for (int i = 0; i < ((p < 2) ? 16 : 8); i++) e.push_back(8'(16*p + i));
        end
        check_cap("burst", e, 1'b1);

        // FT245 back-pressure in the middle of the payload.
        do_reset();
        for (int i = 0; i < 6; i++) push1(1, 8'(8'h60 + i));
        for (int k = 0; k < 20; k++) step(1'b0, '0, '0, 4'h2, (k >= 5 && k < 8));
        e = {8'hA1, 8'h06, 8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
        check_cap("stall", e, 1'b1);

        // Full FIFO: extra push rejected, refill while draining.
        do_reset();
        for (int i = 0; i < 32; i++) push1(0, 8'(8'h80 + i));
        check("full_ready", int'(bus.in_ready[0]), 0);
        push1(0, 8'hEE);
        for (int k = 0; k < 40; k++) step(1'b0, 4'h1, lane(0, 8'(8'hC0 + k)), 4'h1, 1'b0);
        idle(80, 4'h1, 1'b0);
        e.delete();
        e.push_back(8'hA0); e.push_back(8'd16);
        for (int i = 0; i < 16; i++) e.push_back(8'(8'h80 + i));
        check_cap("full", e, 1'b0);

        // Reset in the middle of a payload.
        do_reset();
        for (int i = 0; i < 5; i++) push1(3, 8'(8'h50 + i));
        idle(4, 4'h8, 1'b0);
        step(1'b1, '0, '0, 4'h8, 1'b0);
        check("rst_wr_n", int'(bus.usb_wr_n), 1);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_ready", int'(bus.in_ready), 'hF);
        cap.delete();
        idle(10, 4'hF, 1'b0);
        check("rst_no_writes", cap.size(), 0);

        // Random traffic against the model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            v  = CH'($urandom);
            en = ($urandom_range(0, 3) == 0) ? CH'($urandom) : '1;
            for (int c = 0; c < CH; c++) d[8*c +: 8] = 8'($urandom);
            step(($urandom_range(0, 599) == 0), v, d, en, ($urandom_range(0, 3) == 0));
        end
        cap.delete();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
